// File: rtl/mau_pkg.sv
// mau_pkg: shared state encodings and op layout for the memory access unit
package mau_pkg;
  typedef enum logic [2:0] {IDLE, RADDR, RDATA, WRITE, ERR} state_t;
  typedef struct packed {
    logic we;
    logic is_byte;
  } op_t;
endpackage

// File: rtl/mau_byte_lane.sv
// mau_byte_lane: byte extract (zero-extended) and byte merge on the MSB lane
module mau_byte_lane #(
  parameter int WORD  = 4,
  parameter int WIDTH = 8
) (
  input  logic [WORD*WIDTH-1:0] word,
  input  logic [WIDTH-1:0]      data,
  output logic [WORD*WIDTH-1:0] ext,
  output logic [WORD*WIDTH-1:0] merged
);
  // ram_ad is the exact byte address, so the addressed byte always sits in the MSB lane
  assign ext    = {{(WORD-1)*WIDTH{1'b0}}, word[WORD*WIDTH-1 -: WIDTH]};
  assign merged = {data, word[(WORD-1)*WIDTH-1:0]};
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store initiator with byte load/store and range check
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int WORD       = 4,
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_byte,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] ram_ad,
  output logic [31:0] ram_d,
  output logic        ram_we,
  input  logic [31:0] ram_q
);
  state_t state, nxt;
  op_t op;
  logic [31:0] ext, merged;
  logic oor, load_rsp;
  mau_byte_lane #(.WORD(WORD), .WIDTH(WIDTH)) u_lane (
    .word(ram_q),
    .data(ram_d[WIDTH-1:0]),
    .ext(ext),
    .merged(merged)
  );
  assign oor = |req_addr[31:ADDR_WIDTH];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= IDLE;
      op     <= '0;
      ram_ad <= '0;
      ram_d  <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && req_valid) begin
        op     <= '{we: req_we, is_byte: req_byte};
        ram_ad <= req_addr;
        ram_d  <= req_wdata;
      end else if (state == RDATA && op.we) begin
        ram_d <= merged;
      end
    end
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (req_valid) nxt = oor ? ERR : (req_we && !req_byte) ? WRITE : RADDR;
      RADDR:   nxt = RDATA;
      RDATA:   nxt = op.we ? WRITE : IDLE;
      default: nxt = IDLE;
    endcase
  end
  assign load_rsp   = state == RDATA && !op.we;
  assign req_ready  = state == IDLE;
  assign ram_we     = state == WRITE;
  assign resp_err   = state == ERR;
  assign resp_valid = load_rsp || ram_we || resp_err;
  assign resp_rdata = load_rsp ? (op.is_byte ? ext : ram_q) : '0;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of the load/store unit against a byte RAM model
module tb_mem_access_unit;
  logic        clk = 0, rst_n = 0;
  logic        req_valid = 0, req_we = 0, req_byte = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        req_ready, resp_valid, resp_err, ram_we;
  logic [31:0] resp_rdata, ram_ad, ram_d, ram_q;
  logic [7:0]  mem [256];
  logic [7:0]  a0, a1, a2, a3;
  int vec = 0, miss = 0, we_seen = 0;
  int lat, wes, base;
  logic [31:0] rd;
  logic er;

  mem_access_unit #(.WORD(4), .WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_byte(req_byte),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .ram_ad(ram_ad), .ram_d(ram_d), .ram_we(ram_we), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  assign a0 = ram_ad[7:0];
  assign a1 = a0 + 8'd1;
  assign a2 = a0 + 8'd2;
  assign a3 = a0 + 8'd3;
  always @(posedge clk) begin
    if (ram_we) begin
      mem[a0] <= ram_d[31:24];
      mem[a1] <= ram_d[23:16];
      mem[a2] <= ram_d[15:8];
      mem[a3] <= ram_d[7:0];
    end
    ram_q <= {mem[a0], mem[a1], mem[a2], mem[a3]};
  end

  always @(negedge clk) if (ram_we) we_seen++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic xact(input logic we, input logic bt, input logic [31:0] a, input logic [31:0] d,
                      output int l, output logic [31:0] r, output logic e, output int w);
    @(negedge clk);
    req_valid = 1; req_we = we; req_byte = bt; req_addr = a; req_wdata = d;
    @(posedge clk);
    #1 req_valid = 0;
    l = 0; w = 0; r = 'x; e = 'x;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (ram_we) w++;
      if (resp_valid) begin
        l = i; r = resp_rdata; e = resp_err;
        break;
      end
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_rvalid", resp_valid, 0);
    chk("rst_err", resp_err, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_ad", ram_ad, 0);
    chk("rst_d", ram_d, 0);
    rst_n = 1;
    // reset asserted mid-cycle while a word store is in WRITE
    @(negedge clk);
    req_valid = 1; req_we = 1; req_byte = 0; req_addr = 32'h40; req_wdata = 32'h1234_5678;
    @(posedge clk);
    #1 req_valid = 0;
    #2;
    chk("pre_rst_we", ram_we, 1);
    chk("pre_rst_rv", resp_valid, 1);
    rst_n = 0;
    #1;
    chk("async_we", ram_we, 0);
    chk("async_rv", resp_valid, 0);
    chk("async_ready", req_ready, 1);
    @(negedge clk) rst_n = 1;

    xact(1, 0, 32'h10, 32'hDEAD_BEEF, lat, rd, er, wes);
    chk("str_lat", lat, 1); chk("str_we", wes, 1); chk("str_rd", rd, 0); chk("str_err", er, 0);
    xact(0, 0, 32'h10, 32'h0, lat, rd, er, wes);
    chk("ldr_lat", lat, 2); chk("ldr_rd", rd, 32'hDEAD_BEEF); chk("ldr_we", wes, 0);
    xact(1, 1, 32'h11, 32'hAAAA_AA55, lat, rd, er, wes);
    chk("strb_lat", lat, 3); chk("strb_we", wes, 1); chk("strb_rd", rd, 0);
    xact(0, 0, 32'h10, 32'h0, lat, rd, er, wes);
    chk("ldr2_rd", rd, 32'hDE55_BEEF);
    xact(0, 1, 32'h11, 32'h0, lat, rd, er, wes);
    chk("ldrb_lat", lat, 2); chk("ldrb_rd", rd, 32'h0000_0055);
    xact(0, 1, 32'h13, 32'h0, lat, rd, er, wes);
    chk("ldrb13_rd", rd, 32'h0000_00EF);
    xact(0, 0, 32'h100, 32'h0, lat, rd, er, wes);
    chk("oor_lat", lat, 1); chk("oor_err", er, 1); chk("oor_rd", rd, 0); chk("oor_we", wes, 0);
    xact(1, 0, 32'h8000_0010, 32'hFFFF_FFFF, lat, rd, er, wes);
    chk("oor_st_err", er, 1); chk("oor_st_we", wes, 0);
    xact(0, 0, 32'h10, 32'h0, lat, rd, er, wes);
    chk("oor_st_mem", rd, 32'hDE55_BEEF);

    // reset while a byte store sits in RDATA
    @(negedge clk);
    req_valid = 1; req_we = 1; req_byte = 1; req_addr = 32'h11; req_wdata = 32'h99;
    @(posedge clk);
    #1 req_valid = 0;
    base = we_seen;
    @(posedge clk);
    #2 rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    chk("abort_we", we_seen - base, 0);
    xact(0, 1, 32'h11, 32'h0, lat, rd, er, wes);
    chk("abort_mem", rd, 32'h0000_0055);

    // request held high: one accept per load, ready only in IDLE
    @(negedge clk);
    req_valid = 1; req_we = 0; req_byte = 0; req_addr = 32'h10;
    for (int i = 0; i < 6; i++) begin
      chk("hold_ready", req_ready, (i % 3) == 0);
      chk("hold_rvalid", resp_valid, (i % 3) == 2);
      if (i % 3 == 2) chk("hold_rd", resp_rdata, 32'hDE55_BEEF);
      @(negedge clk);
    end
    req_valid = 0;
    chk("hold_idle", req_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation ran past its time limit");
    $fatal(1);
  end
endmodule
